// File: rtl/routine_pkg.sv
// routine_pkg: shared routine-bus layout and 7-segment glyphs used by all routine sources.
`default_nettype none

package routine_pkg;

    localparam int ROUTINE_W   = 47;
    localparam int AWAIT_BIT   = 46;
    localparam int LED_RED_LSB = 36;
    localparam int LED_GRN_LSB = 28;
    localparam int DISP3_LSB   = 21;
    localparam int DISP2_LSB   = 14;
    localparam int DISP1_LSB   = 7;
    localparam int DISP0_LSB   = 0;

    // Active-low segments, bit order gfedcba, indexed by hex value
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        SCAN_UP   = 2'd0,
        SCAN_DOWN = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/routine_scan_if.sv
// routine_scan_if: routine bus from a routine source to the decoder, plus the decoder's restart pulse.
`default_nettype none

interface routine_scan_if;
    import routine_pkg::*;

    logic                 restart;
    logic [ROUTINE_W-1:0] routine;

    modport master (output restart, input routine);
    modport slave  (input restart, output routine);

endinterface

`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: 4-bit hex value to active-low gfedcba 7-segment pattern.
`default_nettype none

module seg7_hex_decoder
    import routine_pkg::*;
(
    input  wire logic [3:0] hex,
    output logic      [6:0] seg
);

    assign seg = SEG_HEX[hex];

endmodule

`default_nettype wire

// File: rtl/routine_scan.sv
// routine_scan: bouncing red-LED scanner routine with hex pass counter and completion flag.
`default_nettype none

module routine_scan
    import routine_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int PASSES   = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    routine_scan_if.slave   bus
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   PASS_LAST = 16'(PASSES);

    scan_state_t   state, state_nxt;
    logic [PW-1:0] prescaler, prescaler_nxt;
    logic [3:0]    pos, pos_nxt;
    logic [15:0]   passes, passes_nxt;

    logic          step;
    logic          done;
    logic          dir;
    logic [9:0]    led_red;
    logic [7:0]    led_grn;
    logic [6:0]    disp [4];

    assign step = (prescaler == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN_UP;
            prescaler <= '0;
            pos       <= 4'd0;
            passes    <= 16'd0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            pos       <= pos_nxt;
            passes    <= passes_nxt;
        end
    end

    // Restart wins over any step or completion landing on the same edge
    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        pos_nxt       = pos;
        passes_nxt    = passes;
        if (bus.restart) begin
            state_nxt     = SCAN_UP;
            prescaler_nxt = '0;
            pos_nxt       = 4'd0;
            passes_nxt    = 16'd0;
        end else if (state != SCAN_DONE) begin
            prescaler_nxt = step ? '0 : prescaler + 1'b1;
            if (step) begin
                case (state)
                    SCAN_UP: begin
                        if (pos == 4'd9) begin
                            state_nxt = SCAN_DOWN;
                            pos_nxt   = 4'd8;
                        end else begin
                            pos_nxt = pos + 4'd1;
                        end
                    end
                    SCAN_DOWN: begin
                        pos_nxt = pos - 4'd1;
                        if (pos == 4'd1) begin
                            passes_nxt = passes + 16'd1;
                            state_nxt  = (passes + 16'd1 == PASS_LAST) ? SCAN_DONE : SCAN_UP;
                        end
                    end
                    default: state_nxt = SCAN_UP;
                endcase
            end
        end
    end

    always_comb begin
        done    = (state == SCAN_DONE);
        dir     = (state == SCAN_DOWN);
        led_red = 10'd1 << pos;
        led_grn = {done, 5'b00000, dir && !done, !dir && !done};
    end

    for (genvar i = 0; i < 4; i++) begin : g_digit
        seg7_hex_decoder u_dec (
            .hex (passes[4*i +: 4]),
            .seg (disp[i])
        );
    end

    assign bus.routine = {!done, led_red, led_grn, disp[3], disp[2], disp[1], disp[0]};

endmodule

`default_nettype wire

// File: tb/tb_routine_scan.sv
// tb_routine_scan: directed checks of scan timing, bounce, pass count, completion, restart and reset.
`default_nettype none

module tb_routine_scan;
    import routine_pkg::*;

    localparam logic [46:0] RESET_VAL = {1'b1, 10'h001, 8'h01, 7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [46:0] DONE_VAL  = {1'b0, 10'h001, 8'h80, 7'h40, 7'h40, 7'h40, 7'h24};

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    routine_scan_if bus ();

    routine_scan #(.TICK_DIV(4), .PASSES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [46:0] got, input logic [46:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [46:0] red(input logic [46:0] r);
        return 47'(r[LED_RED_LSB +: 10]);
    endfunction

    function automatic logic [46:0] grn(input logic [46:0] r);
        return 47'(r[LED_GRN_LSB +: 8]);
    endfunction

    function automatic logic [46:0] d0(input logic [46:0] r);
        return 47'(r[DISP0_LSB +: 7]);
    endfunction

    initial begin
        rst_n       = 1'b0;
        bus.restart = 1'b0;
        #1;
        check("reset_state", bus.routine, RESET_VAL);
        cycles(2);
        check("reset_held", bus.routine, RESET_VAL);
        rst_n = 1'b1;

        cycles(3);
        check("step_not_early", red(bus.routine), 47'h001);
        cycles(1);
        check("step_4th_edge", red(bus.routine), 47'h002);

        cycles(32);
        check("top_red", red(bus.routine), 47'h200);
        check("top_grn", grn(bus.routine), 47'h01);
        cycles(4);
        check("bounce_red", red(bus.routine), 47'h100);
        check("bounce_grn", grn(bus.routine), 47'h02);

        cycles(32);
        check("pass1_red", red(bus.routine), 47'h001);
        check("pass1_disp0", d0(bus.routine), 47'h79);
        check("pass1_await", 47'(bus.routine[AWAIT_BIT]), 47'd1);

        cycles(71);
        check("pre_done_await", 47'(bus.routine[AWAIT_BIT]), 47'd1);
        cycles(1);
        check("done_state", bus.routine, DONE_VAL);
        cycles(100);
        check("done_frozen", bus.routine, DONE_VAL);

        bus.restart = 1'b1;
        cycles(3);
        check("restart_held", bus.routine, RESET_VAL);
        bus.restart = 1'b0;
        cycles(3);
        check("restart_resume_early", red(bus.routine), 47'h001);
        cycles(1);
        check("restart_resume_step", red(bus.routine), 47'h002);

        // Back to a fresh start, then reach pos 5 with prescaler at its last count
        bus.restart = 1'b1;
        cycles(1);
        bus.restart = 1'b0;
        cycles(23);
        check("pos5_pre_restart", red(bus.routine), 47'h020);
        bus.restart = 1'b1;
        cycles(1);
        check("restart_priority", bus.routine, RESET_VAL);
        bus.restart = 1'b0;
        cycles(3);
        check("restart_presc_zero", red(bus.routine), 47'h001);
        cycles(1);
        check("restart_first_step", red(bus.routine), 47'h002);

        cycles(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.routine, RESET_VAL);
        cycles(1);
        rst_n = 1'b1;
        cycles(4);
        check("post_reset_step", red(bus.routine), 47'h002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/routine_scan.md
# routine_scan

Scanner light-show routine; one of the four routine sources on the 47-bit routine bus consumed by the routine decoder. Sweeps a single lit red LED back and forth across the 10 red LEDs, shows the completed-pass count in hex on the four 7-segment digits, and drops its Await bit once the configured number of passes is done. Restarts from the beginning whenever the decoder pulses its new-choice signal.

## Interface
- TICK_DIV, 5000000: clock cycles per scan step (10 Hz at 50 MHz); must be ≥ 2.
- PASSES, 4: full round trips (LED 0 → 9 → 0) before completion; 1..65535.
- Clock  input  1  system clock, all state on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Restart  input  1  synchronous restart, driven from the decoder's NewChoice.
- Routine  output  47  routine bus: [46] Await, [45:36] LedRed, [35:28] LedGrn, [27:21] Disp3, [20:14] Disp2, [13:7] Disp1, [6:0] Disp0.

## Operation
- State registers:
  - prescaler: 0..TICK_DIV-1.
  - pos: 0..9.
  - dir: 0 = up, 1 = down.
  - passes: 16-bit.
  - done.
- Reset values: prescaler 0, pos 0, dir up, passes 0, done 0.
- Step pulse: prescaler == TICK_DIV-1. On the pulse, prescaler wraps to 0; otherwise it increments. The prescaler is held at 0 while done.
- Step rules (only when step pulse and !done):
  - Up, pos < 9: pos+1.
  - Up, pos == 9: dir ← down, pos ← 8.
  - Down, pos > 0: pos-1.
  - Down, pos == 1: pos ← 0, dir ← up, passes+1. If passes+1 == PASSES, done ← 1.
- Done: all state frozen until Restart or reset.
- Restart: on the next edge, all state returns to reset values. Restart has priority over a coincident step pulse or completion.
- Output decode is combinational from state, with no extra register:
  - LedRed: one-hot at pos.
  - LedGrn: [0] = !dir && !done, [1] = dir && !done, [6:2] = 0, [7] = done.
  - Disp3..Disp0: hex digits of passes[15:12]..[3:0]. Segments are active-low, bit order gfedcba (0 = 7'b1000000).
  - Await: !done.

## Timing
- One full pass is 18 steps = 18·TICK_DIV cycles.
- Completion occurs PASSES·18·TICK_DIV cycles after reset or Restart.
- Routine reflects the new state in the same cycle the state register updates, i.e. zero cycles after the clock edge.
- Restart asserted for N cycles holds the block at reset state; counting resumes on the first edge after Restart deasserts.
- Resetn low forces reset state asynchronously, mid-step included. Release is synchronous to Clock at the integration level.

## Structure
- Shared package routine_pkg holds:
  - ROUTINE_W = 47.
  - Field offset constants for Await, LedRed, LedGrn and Disp3..0.
  - The active-low segment constants for hex 0-F.
- Sub-module seg7_hex_decoder (4-bit in, 7-bit active-low out), instantiated four times. It is shared with other routines.
- Prescaler width is $clog2(TICK_DIV).

## Test plan
All scenarios use TICK_DIV=4, PASSES=2.

- **Reset:** Resetn low → Routine[46]=1, LedRed=10'b0000000001, LedGrn=8'h01, all digits 7'b1000000.
- **Step timing:** release reset → LedRed changes to 10'b0000000010 exactly on the 4th rising edge, not earlier.
- **Bounce:**
  - After 9 steps (36 cycles) → LedRed[9]=1, LedGrn=8'h01.
  - After step 10 → LedRed[8]=1, LedGrn=8'h02.
- **Pass count:** after 18 steps → LedRed[0]=1, Disp0=7'b1111001 (1), Await still 1.
- **Completion:**
  - After 36 steps → Await=0, LedGrn=8'h80, Disp0=7'b0100100 (2).
  - 100 further cycles → Routine unchanged.
- **Restart/reset priority:**
  - Restart asserted on the cycle prescaler==3 at pos 5 → next edge pos 0, passes 0, prescaler 0.
  - Resetn pulsed low mid-prescaler → immediate reset outputs, no clock edge required.
